vpg_mode_ctrl: RTL and testbench
================================

// Module: vpg_mode_ctrl
// PURPOSE
//  Upstream control stage for vpg, running on clk_100. Debounces three raw push-buttons (next mode, previous mode, colour).
//  Drives vpg's mode, mode_change and disp_color inputs.
//  Paces mode changes so a new one is issued only after the pixel PLL has re-locked from the previous one.
//  Issues one automatic mode_change after reset so the PLL is always configured to DEFAULT_MODE.
// PARAMETERS
//  DEBOUNCE_CYCLES  2000000   consecutive stable cycles to accept a key level (20 ms)
//  NUM_MODES        10        valid modes 0..NUM_MODES-1, max 16
//  DEFAULT_MODE     0         mode after reset
//  HOLDOFF_CYCLES   1024      minimum wait after mode_change before pll_locked is trusted
//  LOCK_TIMEOUT     10000000  cycles allowed after holdoff for lock (100 ms)
// PORTS
//  clk_100       in   1  100 MHz system clock
//  reset_n       in   1  asynchronous, active-low reset
//  key_next_n    in   1  raw button, low = pressed, asynchronous
//  key_prev_n    in   1  raw button, low = pressed, asynchronous
//  key_color_n   in   1  raw button, low = pressed, asynchronous
//  pll_locked    in   1  vpg pixel-PLL lock, asynchronous to clk_100
//  mode          out  4  timing mode to vpg
//  mode_change   out  1  one-cycle strobe to vpg
//  disp_color    out  2  colour pattern select to vpg
//  busy          out  1  high while a mode change is in flight
//  lock_timeout  out  1  sticky: last change did not lock in time
// BEHAVIOUR
//  Reset values: mode=DEFAULT_MODE, mode_change=0, disp_color=0, busy=1, lock_timeout=0, FSM=INIT.
//  Input sync
//   - all four async inputs pass through 2-flop synchronisers; every decision uses synchronised values only.
//  Debounce, per key
//   - stable level (reset = released) flips only after DEBOUNCE_CYCLES consecutive cycles of the opposite synchronised level.
//   - any glitch restarts the count.
//   - press event = 1-cycle pulse when the stable level goes released->pressed; release gives no event.
//  Colour
//   - on a colour press event, disp_color <= disp_color+1 (mod 4, 3 wraps to 0) on the next edge.
//   - works in every FSM state and is independent of the PLL.
//  FSM: INIT, IDLE, ISSUE, HOLD, WAIT_LOCK
//   INIT
//    - first cycle after reset release: go to ISSUE with mode unchanged.
//   IDLE (busy=0)
//    - next event alone: mode <= (mode==NUM_MODES-1) ? 0 : mode+1, then go to ISSUE.
//    - prev event alone: mode <= (mode==0) ? NUM_MODES-1 : mode-1, then go to ISSUE.
//    - next and prev in the same cycle: both ignored, stay in IDLE.
//   ISSUE
//    - mode_change=1 for exactly this cycle.
//    - mode was updated one cycle earlier and is held stable until the next IDLE transition.
//    - load the counter with HOLDOFF_CYCLES-1, then go to HOLD.
//   HOLD
//    - count down; at 0 load LOCK_TIMEOUT-1 and go to WAIT_LOCK.
//    - pll_locked is ignored here, which masks vpg's stale lock before the PLL reconfigures.
//   WAIT_LOCK
//    - synchronised pll_locked=1: clear lock_timeout, go to IDLE.
//    - counter reaches 0 without lock: set lock_timeout, go to IDLE so the user can retry.
//  busy=1 in INIT, ISSUE, HOLD and WAIT_LOCK.
//  Next/prev events while busy=1 are discarded, not queued.
//  Latency: key press event in cycle N -> mode updated at N+1 -> mode_change high in cycle N+1 -> busy high from N+1.
//  Counters: one shared down-counter, width $clog2(max(HOLDOFF_CYCLES,LOCK_TIMEOUT)).
//   Debounce counters are width $clog2(DEBOUNCE_CYCLES+1) and saturate.
//  Reset mid-operation: everything returns to reset values asynchronously.
//   After release the INIT re-issue reconfigures the PLL to DEFAULT_MODE.
// STRUCTURE
//  - vpg_pkg holds the MODE_* encodings shared with mode_lut and pll_reconfig_fsm, VPG_NUM_MODES and the FSM state localparams.
//  - One sub-module, key_debounce: 2-flop sync + debounce + press pulse, parameter DEBOUNCE_CYCLES, instantiated three times.
//   The pll_locked synchroniser stays inline.
// TESTING (DEBOUNCE_CYCLES=8, HOLDOFF_CYCLES=4, LOCK_TIMEOUT=32, NUM_MODES=10, DEFAULT_MODE=0)
//  - reset release, pll_locked low then high after 20 cycles -> one mode_change with mode=0, busy drops 1 cycle after lock is seen post-sync.
//  - key_next_n low with 5-cycle bounces, then steady -> a single event 8 cycles after the last bounce, mode 0->1, one mode_change.
//  - mode=9, next press -> mode=0; mode=0, prev press -> mode=9; next+prev events in the same cycle -> no change, no strobe.
//  - next pressed while busy in WAIT_LOCK -> no mode change, no second strobe; a press after busy=0 -> accepted.
//  - pll_locked held low -> lock_timeout=1 after 4+32 cycles, busy=0; next change that locks -> lock_timeout=0.
//  - colour pressed 5 times, one during busy -> disp_color 0,1,2,3,0,1; reset mid-HOLD -> all outputs at reset values, INIT re-issues mode 0.

Source files
------------

// File: rtl/vpg_pkg.sv
// Shared definitions for the vpg control path.
// Holds the MODE_* timing-mode encodings, which mode_lut and pll_reconfig_fsm also use.
// Also holds the mode-count limit, the mode-control FSM state type and a mode stepping helper.
package vpg_pkg;

  localparam int unsigned VPG_NUM_MODES = 10;

  localparam logic [3:0] MODE_640X480_60   = 4'd0;
  localparam logic [3:0] MODE_800X600_60   = 4'd1;
  localparam logic [3:0] MODE_1024X768_60  = 4'd2;
  localparam logic [3:0] MODE_1280X720_60  = 4'd3;
  localparam logic [3:0] MODE_1280X1024_60 = 4'd4;
  localparam logic [3:0] MODE_1366X768_60  = 4'd5;
  localparam logic [3:0] MODE_1440X900_60  = 4'd6;
  localparam logic [3:0] MODE_1600X900_60  = 4'd7;
  localparam logic [3:0] MODE_1680X1050_60 = 4'd8;
  localparam logic [3:0] MODE_1920X1080_60 = 4'd9;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StIssue,
    StHold,
    StWaitLock
  } mode_state_e;

  // Step one mode up or down, wrapping within 0..last.
  function automatic logic [3:0] mode_step(logic [3:0] cur, logic [3:0] last, logic up);
    if (up) begin
      return (cur == last) ? 4'd0 : cur + 4'd1;
    end
    return (cur == 4'd0) ? last : cur - 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debounce and press pulse.
// Ports:
//   clk_100  in   system clock
//   reset_n  in   asynchronous active-low reset
//   key_n    in   raw button, low = pressed, asynchronous to clk_100
//   press    out  one-cycle pulse when the debounced level goes released -> pressed
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk_100,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;  // 1 = released
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Count consecutive cycles at the opposite level; any return to the stable level
    // clears the count. The count never passes DEBOUNCE_CYCLES-1, so it cannot wrap.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Upstream control stage for vpg: debounced mode/colour buttons and PLL-paced mode changes.
// A mode change is only issued once the pixel PLL has re-locked (or timed out) from the last one,
// and one change is issued automatically after reset so the PLL always matches DEFAULT_MODE.
// Ports:
//   clk_100       in   100 MHz system clock
//   reset_n       in   asynchronous active-low reset
//   key_next_n    in   raw next-mode button, low = pressed
//   key_prev_n    in   raw previous-mode button, low = pressed
//   key_color_n   in   raw colour button, low = pressed
//   pll_locked    in   vpg pixel-PLL lock, asynchronous
//   mode          out  timing mode to vpg
//   mode_change   out  one-cycle strobe to vpg
//   disp_color    out  colour pattern select to vpg
//   busy          out  high while a mode change is in flight
//   lock_timeout  out  sticky: last change did not lock in time
module vpg_mode_ctrl
  import vpg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned NUM_MODES       = VPG_NUM_MODES,
  parameter int unsigned DEFAULT_MODE    = 0,
  parameter int unsigned HOLDOFF_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT    = 10000000
) (
  input  logic       clk_100,
  input  logic       reset_n,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  input  logic       key_color_n,
  input  logic       pll_locked,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic [1:0] disp_color,
  output logic       busy,
  output logic       lock_timeout
);

  localparam int unsigned CntMax   = (HOLDOFF_CYCLES > LOCK_TIMEOUT) ? HOLDOFF_CYCLES
                                                                      : LOCK_TIMEOUT;
  localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [3:0]  LastMode = 4'(NUM_MODES - 1);
  localparam logic [3:0]  InitMode = 4'(DEFAULT_MODE);

  logic next_ev, prev_ev, color_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .key_n   (key_next_n),
    .press   (next_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .key_n   (key_prev_n),
    .press   (prev_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_color (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .key_n   (key_color_n),
    .press   (color_ev)
  );

  logic [1:0]      lock_sync_q;
  mode_state_e     state_q, state_d;
  logic [3:0]      mode_q, mode_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      color_q, color_d;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    color_d   = color_q + {1'b0, color_ev};
    unique case (state_q)
      StInit: begin
        state_d = StIssue;
      end
      StIdle: begin
        // Simultaneous next and prev cancel each other.
        if (next_ev ^ prev_ev) begin
          mode_d  = mode_step(mode_q, LastMode, next_ev);
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(HOLDOFF_CYCLES - 1);
        state_d = StHold;
      end
      StHold: begin
        // Lock is ignored here: vpg still reports the old lock until the PLL reconfigures.
        if (cnt_q == '0) begin
          cnt_d   = CntW'(LOCK_TIMEOUT - 1);
          state_d = StWaitLock;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitLock: begin
        if (lock_sync_q[1]) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= 2'b00;
      state_q     <= StInit;
      mode_q      <= InitMode;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      color_q     <= 2'd0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      color_q     <= color_d;
    end
  end

  assign mode         = mode_q;
  assign mode_change  = (state_q == StIssue);
  assign busy         = (state_q != StIdle);
  assign disp_color   = color_q;
  assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Scoreboard bench for vpg_mode_ctrl with short debounce/holdoff/timeout settings.
module tb_vpg_mode_ctrl;

  logic       clk_100     = 1'b0;
  logic       reset_n     = 1'b0;
  logic       key_next_n  = 1'b1;
  logic       key_prev_n  = 1'b1;
  logic       key_color_n = 1'b1;
  logic       pll_locked  = 1'b0;
  logic [3:0] mode;
  logic       mode_change;
  logic [1:0] disp_color;
  logic       busy;
  logic       lock_timeout;

  int checks = 0;
  int errors = 0;

  int exp_mode_q[$];
  int exp_color_q[$];

  always #5 clk_100 = ~clk_100;

  vpg_mode_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .NUM_MODES       (10),
    .DEFAULT_MODE    (0),
    .HOLDOFF_CYCLES  (4),
    .LOCK_TIMEOUT    (32)
  ) dut (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .key_next_n   (key_next_n),
    .key_prev_n   (key_prev_n),
    .key_color_n  (key_color_n),
    .pll_locked   (pll_locked),
    .mode         (mode),
    .mode_change  (mode_change),
    .disp_color   (disp_color),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe and every colour change must match the next queued expectation.
  initial begin
    int color_seen;
    color_seen = 0;
    forever begin
      @(posedge clk_100);
      #1;
      if (mode_change) begin
        if (exp_mode_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: mode_change with mode %0d, expected none", mode);
        end else begin
          check("strobe_mode", int'(mode), exp_mode_q.pop_front());
          check("strobe_busy", int'(busy), 1);
        end
      end
      if (!reset_n) begin
        color_seen = int'(disp_color);
      end else if (int'(disp_color) != color_seen) begin
        if (exp_color_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_color: disp_color %0d, expected no change", disp_color);
        end else begin
          check("disp_color", int'(disp_color), exp_color_q.pop_front());
        end
        color_seen = int'(disp_color);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_100);
    #1;
  endtask

  task automatic cycles_until_strobe(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!mode_change && n < 60);
  endtask

  task automatic cycles_until_idle(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (busy && n < 100);
  endtask

  // Hold the chosen keys long enough for a press event, then release and let them settle.
  task automatic press(input logic nx, input logic pv, input logic cl);
    if (nx) key_next_n = 1'b0;
    if (pv) key_prev_n = 1'b0;
    if (cl) key_color_n = 1'b0;
    repeat (14) cyc();
    key_next_n  = 1'b1;
    key_prev_n  = 1'b1;
    key_color_n = 1'b1;
    repeat (14) cyc();
  endtask

  initial begin
    int n;
    int idle_at;

    // Reset values.
    #3;
    check("rst_mode", int'(mode), 0);
    check("rst_mode_change", int'(mode_change), 0);
    check("rst_disp_color", int'(disp_color), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_lock_timeout", int'(lock_timeout), 0);

    // Automatic issue after reset; lock arrives 20 cycles later.
    exp_mode_q.push_back(0);
    cyc();
    cyc();
    reset_n = 1'b1;
    repeat (20) cyc();
    pll_locked = 1'b1;
    cycles_until_idle(n);
    check("lock_to_idle_cycles", n, 3);
    check("init_lock_timeout", int'(lock_timeout), 0);
    check("init_mode", int'(mode), 0);

    // Bouncing next key: only the final steady level counts.
    exp_mode_q.push_back(1);
    repeat (3) begin
      key_next_n = 1'b0;
      repeat (5) cyc();
      key_next_n = 1'b1;
      repeat (5) cyc();
    end
    key_next_n = 1'b0;
    cycles_until_strobe(n);
    check("debounce_latency", n, 11);
    cycles_until_idle(n);
    check("hold_masks_lock_cycles", n, 6);
    key_next_n = 1'b1;
    repeat (14) cyc();
    check("mode_after_next", int'(mode), 1);

    // Prev 1->0, prev wrap 0->9, next wrap 9->0.
    exp_mode_q.push_back(0);
    press(1'b0, 1'b1, 1'b0);
    exp_mode_q.push_back(9);
    press(1'b0, 1'b1, 1'b0);
    check("mode_after_prev_wrap", int'(mode), 9);
    exp_mode_q.push_back(0);
    press(1'b1, 1'b0, 1'b0);
    check("mode_after_next_wrap", int'(mode), 0);

    // Next and prev together: ignored.
    press(1'b1, 1'b1, 1'b0);
    check("mode_after_both", int'(mode), 0);
    check("busy_after_both", int'(busy), 0);

    // Lock never comes; a second press during WAIT_LOCK is discarded.
    pll_locked = 1'b0;
    exp_mode_q.push_back(1);
    key_next_n = 1'b0;
    cycles_until_strobe(n);
    check("strobe_latency_nolock", n, 11);
    idle_at = -1;
    for (int i = 1; i <= 60; i++) begin
      key_next_n = (i >= 12 && i < 26) ? 1'b0 : 1'b1;
      cyc();
      if (!busy && idle_at < 0) idle_at = i;
    end
    check("timeout_cycles", idle_at, 37);
    check("timeout_flag_set", int'(lock_timeout), 1);
    check("mode_after_busy_press", int'(mode), 1);

    // Press after busy drops is accepted and a successful lock clears the flag.
    pll_locked = 1'b1;
    exp_mode_q.push_back(2);
    press(1'b1, 1'b0, 1'b0);
    check("timeout_flag_cleared", int'(lock_timeout), 0);
    check("mode_after_retry", int'(mode), 2);

    // Colour presses, one of them while a mode change is in flight.
    for (int k = 1; k <= 3; k++) begin
      exp_color_q.push_back(k);
      press(1'b0, 1'b0, 1'b1);
    end
    pll_locked = 1'b0;
    exp_mode_q.push_back(3);
    key_next_n = 1'b0;
    cycles_until_strobe(n);
    key_next_n = 1'b1;
    repeat (11) cyc();
    exp_color_q.push_back(0);
    key_color_n = 1'b0;
    repeat (14) cyc();
    key_color_n = 1'b1;
    check("busy_during_color", int'(busy), 1);
    check("color_wrap_while_busy", int'(disp_color), 0);
    cycles_until_idle(n);
    check("timeout_flag_again", int'(lock_timeout), 1);
    pll_locked = 1'b1;
    exp_color_q.push_back(1);
    press(1'b0, 1'b0, 1'b1);
    check("color_final", int'(disp_color), 1);

    // Reset while in HOLD, then INIT re-issues the default mode.
    exp_mode_q.push_back(4);
    key_next_n = 1'b0;
    cycles_until_strobe(n);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_mode", int'(mode), 0);
    check("midrst_mode_change", int'(mode_change), 0);
    check("midrst_disp_color", int'(disp_color), 0);
    check("midrst_busy", int'(busy), 1);
    check("midrst_lock_timeout", int'(lock_timeout), 1 - 1);
    key_next_n = 1'b1;
    repeat (3) cyc();
    exp_mode_q.push_back(0);
    reset_n = 1'b1;
    cycles_until_strobe(n);
    check("init_reissue_latency", n, 1);
    cycles_until_idle(n);
    check("reissue_idle_cycles", n, 6);
    check("mode_after_reissue", int'(mode), 0);

    repeat (5) cyc();
    check("mode_queue_drained", exp_mode_q.size(), 0);
    check("color_queue_drained", exp_color_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
